// File: rtl/aes_inv_cipher_if.sv
// aes_inv_cipher_if - ciphertext, round-key and plaintext handshake bundle
// for the AES-128 inverse cipher. The master drives ciphertext, round keys
// and the plaintext ready; the slave (the cipher) answers.
interface aes_inv_cipher_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_ciphertext;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_plaintext;
    logic         busy;

    modport master (
        output in_valid, in_ciphertext, rk_valid, rk_data, out_ready,
        input  in_ready, rk_req, rk_idx, out_valid, out_plaintext, busy
    );

    modport slave (
        input  in_valid, in_ciphertext, rk_valid, rk_data, out_ready,
        output in_ready, rk_req, rk_idx, out_valid, out_plaintext, busy
    );
endinterface

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher - iterative AES-128 decryption, one round per round-key
// handshake. Round keys are fetched from outside, index 10 down to 0.
// Optional feature: define AES_INV_ABORT_EN to add the 'abort' input, which
// drops an in-flight block and returns to IDLE.
module aes_inv_cipher (
    input  logic clk,
    input  logic rst,
`ifdef AES_INV_ABORT_EN
    input  logic abort,
`endif
    aes_inv_cipher_if.slave bus
);

    typedef enum logic [2:0] {IDLE, KEY10, ROUND, FINAL, DONE} state_t;

    // Inverse S-box, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
    };

    state_t       r_fsm;
    state_t       w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_plain;
    logic [3:0]   r_cnt;
    logic         w_abort;
    logic         w_step;
    logic [127:0] w_isr;
    logic [127:0] w_isb_ark;
    logic [127:0] w_imc;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b111} -: 8];
    endfunction

    // Row r of the block is rotated right by r byte positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    // Column matrix {0e,0b,0d,09} built from repeated xtime.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

`ifdef AES_INV_ABORT_EN
    assign w_abort = abort & (r_fsm != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // A key step only happens on a real handshake, never in an aborting cycle.
    assign w_step    = bus.rk_req & bus.rk_valid & ~w_abort;
    assign w_isr     = inv_shift_rows(r_state);
    assign w_isb_ark = inv_sub_bytes(w_isr) ^ bus.rk_data;
    assign w_imc     = inv_mix_columns(w_isb_ark);

    assign bus.in_ready      = (r_fsm == IDLE) & ~rst;
    assign bus.rk_req        = (r_fsm == KEY10) | (r_fsm == ROUND) | (r_fsm == FINAL);
    assign bus.rk_idx        = bus.rk_req ? r_cnt : 4'd0;
    assign bus.out_valid     = (r_fsm == DONE);
    assign bus.out_plaintext = r_plain;
    assign bus.busy          = (r_fsm != IDLE);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Next-state logic: advance on each key step, leave DONE on output handshake.
    always_comb begin
        w_fsm_next = r_fsm;
        unique case (r_fsm)
            IDLE:    if (bus.in_valid) w_fsm_next = KEY10;
            KEY10:   if (w_step) w_fsm_next = ROUND;
            ROUND:   if (w_step && (r_cnt == 4'd1)) w_fsm_next = FINAL;
            FINAL:   if (w_step) w_fsm_next = DONE;
            DONE:    if (bus.out_ready) w_fsm_next = IDLE;
            default: w_fsm_next = IDLE;
        endcase
        if (w_abort) begin
            w_fsm_next = IDLE;
        end
    end

    // Datapath: load ciphertext, apply one round per key step, capture plaintext.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_plain <= '0;
            r_cnt   <= 4'd10;
        end else begin
            unique case (r_fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= bus.in_ciphertext;
                        r_cnt   <= 4'd10;
                    end
                end
                KEY10: begin
                    if (w_step) begin
                        r_state <= r_state ^ bus.rk_data;
                        r_cnt   <= 4'd9;
                    end
                end
                ROUND: begin
                    if (w_step) begin
                        r_state <= w_imc;
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                FINAL: begin
                    if (w_step) begin
                        r_plain <= w_isb_ark;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb_aes_inv_cipher - directed and randomized checks of aes_inv_cipher.
// The reference is a forward AES-128 encryptor with an arithmetically derived
// S-box: random plaintexts are encrypted here and the DUT must recover them.
module tb_aes_inv_cipher;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic clk;
    logic rst;
`ifdef AES_INV_ABORT_EN
    logic abort;
`endif

    aes_inv_cipher_if bus ();

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox  [0:255];
    logic [127:0] rkTab [0:10];
    logic [127:0] lastPt;

    aes_inv_cipher dut (
        .clk   (clk),
        .rst   (rst),
`ifdef AES_INV_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine transform of the GF(2^8) multiplicative inverse.
    task automatic buildSbox();
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] res;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            res = inv ^ 8'h63;
            b   = inv;
            for (int k = 0; k < 4; k++) begin
                b = {b[6:0], b[7]};
                res ^= b;
            end
            sbox[x] = res;
        end
    endtask

    task automatic keyExpand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rkTab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rkTab[0][127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[4*((i/4 + i%4) % 4) + i%4]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= rkTab[rnd][127 - 8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One block: handshake, 11 key steps (optional stalls), optional output
    // back-pressure, and optionally a reset or abort at key index cutAt.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] expPt,
                                 input int stall, input int outHold,
                                 input int cutAt, input bit useAbort);
        int lat;
        int waitN;
        int totalStall;
        lat        = 0;
        totalStall = 0;
        bus.in_valid      = 1'b1;
        bus.in_ciphertext = ct;
        bus.rk_valid      = 1'b1;
        bus.rk_data       = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready     = (outHold == 0);
        checkOutput("in_ready_accept", bus.in_ready, 1);
        @(posedge clk); #1;
        lat = 1;
        bus.in_valid      = 1'b0;
        bus.in_ciphertext = {$urandom, $urandom, $urandom, $urandom};
        checkOutput("busy_after_accept", bus.busy, 1);
        for (int idx = 10; idx >= 0; idx--) begin
            waitN = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            totalStall += waitN;
            bus.rk_valid = 1'b0;
            bus.rk_data  = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < waitN; k++) begin
                checkOutput("rk_idx_hold", bus.rk_idx, idx);
                @(posedge clk); #1;
                lat++;
            end
            if (idx == cutAt) begin
                if (useAbort) begin
`ifdef AES_INV_ABORT_EN
                    bus.rk_valid = 1'b1;
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    bus.rk_valid = 1'b0;
                    checkOutput("abort_busy", bus.busy, 0);
                    checkOutput("abort_in_ready", bus.in_ready, 1);
                    checkOutput("abort_out_valid", bus.out_valid, 0);
                    checkOutput("abort_rk_req", bus.rk_req, 0);
                    checkOutput("abort_plaintext", bus.out_plaintext, lastPt);
`endif
                end else begin
                    rst = 1'b1;
                    #1;
                    checkOutput("rst_in_ready", bus.in_ready, 0);
                    checkOutput("rst_rk_req", bus.rk_req, 0);
                    checkOutput("rst_rk_idx", bus.rk_idx, 0);
                    checkOutput("rst_out_valid", bus.out_valid, 0);
                    checkOutput("rst_plaintext", bus.out_plaintext, 0);
                    checkOutput("rst_busy", bus.busy, 0);
                    @(posedge clk); #1;
                    rst = 1'b0;
                    #1;
                    checkOutput("rst_release_in_ready", bus.in_ready, 1);
                    checkOutput("rst_release_out_valid", bus.out_valid, 0);
                    lastPt = '0;
                end
                return;
            end
            bus.rk_valid = 1'b1;
            bus.rk_data  = rkTab[idx];
            checkOutput("rk_req_step", bus.rk_req, 1);
            checkOutput("rk_idx_step", bus.rk_idx, idx);
            checkOutput("out_valid_early", bus.out_valid, 0);
            @(posedge clk); #1;
            lat++;
        end
        bus.rk_valid = 1'b1;
        checkOutput("latency", lat, 12 + totalStall);
        checkOutput("out_valid", bus.out_valid, 1);
        checkOutput("plaintext", bus.out_plaintext, expPt);
        checkOutput("rk_req_done", bus.rk_req, 0);
        checkOutput("rk_idx_done", bus.rk_idx, 0);
        checkOutput("in_ready_done", bus.in_ready, 0);
        for (int k = 0; k < outHold; k++) begin
            bus.in_valid      = (k % 2 == 0);
            bus.in_ciphertext = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            checkOutput("out_valid_hold", bus.out_valid, 1);
            checkOutput("plaintext_hold", bus.out_plaintext, expPt);
            checkOutput("in_ready_hold", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("out_valid_drop", bus.out_valid, 0);
        checkOutput("in_ready_idle", bus.in_ready, 1);
        checkOutput("busy_idle", bus.busy, 0);
        lastPt = expPt;
    endtask

    // Directed sequence followed by randomized keys and plaintexts.
    initial begin
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_ciphertext = '0;
        bus.rk_valid      = 1'b0;
        bus.rk_data       = '0;
        bus.out_ready     = 1'b0;
        lastPt            = '0;
`ifdef AES_INV_ABORT_EN
        abort             = 1'b0;
`endif
        buildSbox();
        @(posedge clk); #1;
        checkOutput("reset_in_ready", bus.in_ready, 0);
        checkOutput("reset_rk_req", bus.rk_req, 0);
        checkOutput("reset_rk_idx", bus.rk_idx, 0);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_plaintext", bus.out_plaintext, 0);
        checkOutput("reset_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("release_in_ready", bus.in_ready, 1);

        $display("[TB] FIPS-197 C.1 vector, directed cases");
        keyExpand(C1_KEY);
        applyStimulus(C1_CT, C1_PT, 0, 0, -1, 1'b0);
        applyStimulus(C1_CT, C1_PT, 3, 0, -1, 1'b0);
        applyStimulus(C1_CT, C1_PT, 0, 5, -1, 1'b0);
        applyStimulus(C1_CT, C1_PT, 0, 0, 5, 1'b0);
        applyStimulus(C1_CT, C1_PT, 0, 0, -1, 1'b0);

`ifdef AES_INV_ABORT_EN
        $display("[TB] abort cases");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_idle_busy", bus.busy, 0);
        checkOutput("abort_idle_in_ready", bus.in_ready, 1);
        applyStimulus(C1_CT, C1_PT, 0, 0, 7, 1'b1);
        applyStimulus(C1_CT, C1_PT, 0, 0, -1, 1'b0);
`endif

        $display("[TB] randomized keys and plaintexts");
        for (int n = 0; n < 6; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            keyExpand(key);
            ct = encrypt(pt);
            applyStimulus(ct, pt, -1, int'($urandom_range(0, 2)), -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
